// File: rtl/fp_div_arb_pkg.sv
// rtl/fp_div_arb_pkg.sv - shared types and constants for the FP divider arbiter
package fp_div_arb_pkg;

  localparam int STATUS_W   = 8;
  localparam int RND_W      = 3;
  localparam int DEF_SEQ_W  = 6;
  localparam int DEF_IDX_W  = 2;
  localparam int DEF_DATA_W = 16;

  // Layout of a divider ID for the default configuration; the top slices by parameter.
  typedef struct packed {
    logic [DEF_SEQ_W-1:0] seq;
    logic [DEF_IDX_W-1:0] idx;
  } div_id_t;

  typedef struct packed {
    logic                  valid;
    logic [DEF_DATA_W-1:0] z;
    logic [STATUS_W-1:0]   status;
  } rsp_slot_t;

endpackage

// File: rtl/fp_div_arbiter_if.sv
// rtl/fp_div_arbiter_if.sv - launch/return bus between the arbiter and the divider wrapper
interface fp_div_arbiter_if
  import fp_div_arb_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ID_W   = 8
);

  logic [DATA_W-1:0]   div_a;
  logic [DATA_W-1:0]   div_b;
  logic [RND_W-1:0]    div_rnd;
  logic                div_launch;
  logic [ID_W-1:0]     div_launch_id;
  logic                div_pipe_full;
  logic                div_accept_n;
  logic                div_arrive;
  logic [ID_W-1:0]     div_arrive_id;
  logic [DATA_W-1:0]   div_z;
  logic [STATUS_W-1:0] div_status;

  modport master (
    output div_a, div_b, div_rnd, div_launch, div_launch_id, div_accept_n,
    input  div_pipe_full, div_arrive, div_arrive_id, div_z, div_status
  );

  modport slave (
    input  div_a, div_b, div_rnd, div_launch, div_launch_id, div_accept_n,
    output div_pipe_full, div_arrive, div_arrive_id, div_z, div_status
  );

endinterface

// File: rtl/fp_div_rr_arb.sv
// rtl/fp_div_rr_arb.sv - round-robin arbiter: first request at or after the pointer wins
module fp_div_rr_arb
  import fp_div_arb_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          en,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] idx;
  logic          found;

  // N is a power of two, so the pointer sum wraps naturally.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int k = 0; k < N; k++) begin
      idx = ptr_q + IW'(k);
      if (en && !found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
    ptr_d = found ? grant_idx + 1'b1 : ptr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/fp_div_arbiter.sv
// rtl/fp_div_arbiter.sv - shares one pipelined FP divider among NUM_REQ requesters
// Optional FP_DIV_ARB_SEQ_CHECK_EN: checks arrival sequence numbers per requester.
module fp_div_arbiter
  import fp_div_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int DATA_W       = 16,
  parameter int SEQ_W        = 6,
  parameter int INFLIGHT_MAX = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_REQ-1:0]                 req_valid,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]     req_a,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]     req_b,
  input  logic [NUM_REQ-1:0][RND_W-1:0]      req_rnd,
  output logic [NUM_REQ-1:0]                 rsp_valid,
  input  logic [NUM_REQ-1:0]                 rsp_ready,
  output logic [DATA_W-1:0]                  rsp_z,
  output logic [NUM_REQ-1:0][STATUS_W-1:0]   rsp_status,
  output logic [NUM_REQ-1:0][DATA_W-1:0]     rsp_z_slot,
  fp_div_arbiter_if.master                   div,
  output logic                               seq_err
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int ID_W   = SEQ_W + IDX_W;
  localparam int CRED_W = $clog2(INFLIGHT_MAX + 1);

  logic [NUM_REQ-1:0]               grant;
  logic [IDX_W-1:0]                 gnt_idx;
  logic                             arb_en;
  logic                             launch;

  logic [CRED_W-1:0]                credit_q, credit_d;
  logic [NUM_REQ-1:0][SEQ_W-1:0]    seq_cnt_q, seq_cnt_d;

  logic [DATA_W-1:0]                div_a_q, div_a_d;
  logic [DATA_W-1:0]                div_b_q, div_b_d;
  logic [RND_W-1:0]                 div_rnd_q, div_rnd_d;
  logic                             div_launch_q, div_launch_d;
  logic [ID_W-1:0]                  div_launch_id_q, div_launch_id_d;

  logic [NUM_REQ-1:0]               slot_valid_q, slot_valid_d;
  logic [NUM_REQ-1:0][DATA_W-1:0]   slot_z_q, slot_z_d;
  logic [NUM_REQ-1:0][STATUS_W-1:0] slot_st_q, slot_st_d;
  logic                             seq_err_q, seq_err_d;

  logic [IDX_W-1:0]                 tgt;
  logic                             accept_n;
  logic                             arr_take;
  logic                             underflow;
  logic                             slot_wr;

  // rst_n gates the enable so req_ready reads 0 while reset is held.
  assign arb_en = rst_n && (credit_q < CRED_W'(INFLIGHT_MAX)) && !div.div_pipe_full;

  fp_div_rr_arb #(.N(NUM_REQ)) u_rr_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_valid),
    .en        (arb_en),
    .grant     (grant),
    .grant_idx (gnt_idx)
  );

  assign launch    = |grant;
  assign tgt       = div.div_arrive_id[IDX_W-1:0];
  assign accept_n  = div.div_arrive & slot_valid_q[tgt] & ~rsp_ready[tgt];
  assign arr_take  = div.div_arrive & ~accept_n;
  assign underflow = arr_take && (credit_q == '0);
  assign slot_wr   = arr_take && !underflow;

  always_comb begin
    div_launch_d    = launch;
    div_a_d         = div_a_q;
    div_b_d         = div_b_q;
    div_rnd_d       = div_rnd_q;
    div_launch_id_d = div_launch_id_q;
    seq_cnt_d       = seq_cnt_q;
    if (launch) begin
      div_a_d            = req_a[gnt_idx];
      div_b_d            = req_b[gnt_idx];
      div_rnd_d          = req_rnd[gnt_idx];
      div_launch_id_d    = {seq_cnt_q[gnt_idx], gnt_idx};
      seq_cnt_d[gnt_idx] = seq_cnt_q[gnt_idx] + 1'b1;
    end
  end

  always_comb begin
    credit_d = credit_q;
    case ({launch, slot_wr})
      2'b10:   credit_d = credit_q + 1'b1;
      2'b01:   credit_d = credit_q - 1'b1;
      default: credit_d = credit_q;
    endcase
  end

  // Drain first, then refill, so a same-cycle drain+fill leaves the slot valid.
  always_comb begin
    slot_valid_d = slot_valid_q & ~rsp_ready;
    slot_z_d     = slot_z_q;
    slot_st_d    = slot_st_q;
    if (slot_wr) begin
      slot_valid_d[tgt] = 1'b1;
      slot_z_d[tgt]     = div.div_z;
      slot_st_d[tgt]    = div.div_status;
    end
  end

`ifdef FP_DIV_ARB_SEQ_CHECK_EN
  logic [NUM_REQ-1:0][SEQ_W-1:0] exp_seq_q, exp_seq_d;
  logic [SEQ_W-1:0]              arr_seq;

  assign arr_seq = div.div_arrive_id[ID_W-1:IDX_W];

  always_comb begin
    exp_seq_d = exp_seq_q;
    seq_err_d = seq_err_q | underflow;
    if (slot_wr) begin
      exp_seq_d[tgt] = exp_seq_q[tgt] + 1'b1;
      if (arr_seq != exp_seq_q[tgt]) begin
        seq_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_seq_q <= '0;
    end else begin
      exp_seq_q <= exp_seq_d;
    end
  end
`else
  always_comb begin
    seq_err_d = seq_err_q | underflow;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_q        <= '0;
      seq_cnt_q       <= '0;
      div_a_q         <= '0;
      div_b_q         <= '0;
      div_rnd_q       <= '0;
      div_launch_q    <= 1'b0;
      div_launch_id_q <= '0;
      slot_valid_q    <= '0;
      slot_z_q        <= '0;
      slot_st_q       <= '0;
      seq_err_q       <= 1'b0;
    end else begin
      credit_q        <= credit_d;
      seq_cnt_q       <= seq_cnt_d;
      div_a_q         <= div_a_d;
      div_b_q         <= div_b_d;
      div_rnd_q       <= div_rnd_d;
      div_launch_q    <= div_launch_d;
      div_launch_id_q <= div_launch_id_d;
      slot_valid_q    <= slot_valid_d;
      slot_z_q        <= slot_z_d;
      slot_st_q       <= slot_st_d;
      seq_err_q       <= seq_err_d;
    end
  end

  // Lowest valid slot drives the shared bus.
  always_comb begin
    rsp_z = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (slot_valid_q[i]) begin
        rsp_z = slot_z_q[i];
      end
    end
  end

  assign req_ready         = grant;
  assign rsp_valid         = slot_valid_q;
  assign rsp_status        = slot_st_q;
  assign rsp_z_slot        = slot_z_q;
  assign seq_err           = seq_err_q;
  assign div.div_a         = div_a_q;
  assign div.div_b         = div_b_q;
  assign div.div_rnd       = div_rnd_q;
  assign div.div_launch    = div_launch_q;
  assign div.div_launch_id = div_launch_id_q;
  assign div.div_accept_n  = accept_n;

endmodule

// File: tb/tb_fp_div_arbiter.sv
// tb/tb_fp_div_arbiter.sv - randomized scoreboard bench for fp_div_arbiter with a divider model
module tb_fp_div_arbiter;

  typedef struct { logic [15:0] z; logic [7:0] st; } exp_t;
  typedef struct { logic [7:0] id; logic [15:0] z; logic [7:0] st; int t_rdy; } pe_t;
  typedef struct { logic [7:0] id; logic [15:0] a; logic [15:0] b; logic [2:0] rnd; } lp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [3:0]       req_valid, req_ready, rsp_valid, rsp_ready;
  logic [3:0][15:0] req_a, req_b, rsp_z_slot;
  logic [3:0][2:0]  req_rnd;
  logic [15:0]      rsp_z;
  logic [3:0][7:0]  rsp_status;
  logic             seq_err;

  fp_div_arbiter_if #(.DATA_W(16), .ID_W(8)) dif ();

  fp_div_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_rnd    (req_rnd),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_z      (rsp_z),
    .rsp_status (rsp_status),
    .rsp_z_slot (rsp_z_slot),
    .div        (dif),
    .seq_err    (seq_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int lat = 4;
  int p_req = 0, p_rdy = 0, p_full = 0;
  int cm = 0, ptr_m = 0;
  logic [3:0] req_mask = '0;
  logic [3:0] act = '0;
  logic [3:0] slot_m = '0;
  logic [5:0] seq_m [4];
  logic       seq_err_m = 1'b0;
  logic       inj = 1'b0;
  logic [15:0] last_a = '0;
  exp_t exp_q [4][$];
  pe_t  dpipe [$];
  lp_t  lpend [$];

  function automatic void chk(string nm, logic [31:0] got, logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, got, want, cyc);
    end
  endfunction

  // Stand-in divider: exact for divide-by-one, otherwise any fixed function of the operands.
  function automatic logic [15:0] fdiv(logic [15:0] a, logic [15:0] b, logic [2:0] rnd);
    if (b == 16'h3C00) return a;
    return (a ^ {b[7:0], b[15:8]}) + 16'(rnd);
  endfunction

  function automatic logic [7:0] fst(logic [15:0] b, logic [2:0] rnd);
    return {b[4:0], rnd};
  endfunction

  function automatic void clear_model();
    cm = 0; ptr_m = 0; slot_m = '0; seq_err_m = 1'b0; inj = 1'b0; last_a = '0;
    for (int i = 0; i < 4; i++) begin
      seq_m[i] = '0;
      exp_q[i].delete();
    end
    dpipe.delete();
    lpend.delete();
  endfunction

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      if (!act[i] && req_mask[i] && ($urandom_range(99) < p_req)) begin
        act[i]     = 1'b1;
        req_a[i]   = 16'($urandom);
        req_b[i]   = 16'($urandom);
        req_rnd[i] = 3'($urandom);
      end
      rsp_ready[i] = ($urandom_range(99) < p_rdy);
    end
    req_valid         = act;
    dif.div_pipe_full = ($urandom_range(99) < p_full);
    if (inj) begin
      dif.div_arrive    = 1'b1;
      dif.div_arrive_id = 8'h01;
      dif.div_z         = 16'hDEAD;
      dif.div_status    = 8'hEE;
    end else if (dpipe.size() > 0 && dpipe[0].t_rdy <= cyc) begin
      dif.div_arrive    = 1'b1;
      dif.div_arrive_id = dpipe[0].id;
      dif.div_z         = dpipe[0].z;
      dif.div_status    = dpipe[0].st;
    end else begin
      dif.div_arrive    = 1'b0;
      dif.div_arrive_id = 8'($urandom);
      dif.div_z         = 16'($urandom);
      dif.div_status    = 8'($urandom);
    end
  endtask

  task automatic step();
    logic [3:0] eg;
    int         g;
    int         t;
    logic       exp_acc_n;
    logic       fill;
    lp_t        lp;
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      chk("rst_req_ready", 32'(req_ready), 32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_div_launch", 32'(dif.div_launch), 32'h0);
      chk("rst_div_a", 32'(dif.div_a), 32'h0);
      chk("rst_div_b", 32'(dif.div_b), 32'h0);
      chk("rst_div_rnd", 32'(dif.div_rnd), 32'h0);
      chk("rst_div_launch_id", 32'(dif.div_launch_id), 32'h0);
      chk("rst_div_accept_n", 32'(dif.div_accept_n), 32'h0);
      chk("rst_seq_err", 32'(seq_err), 32'h0);
      chk("rst_rsp_z", 32'(rsp_z), 32'h0);
    end else begin
      if (lpend.size() > 0) begin
        lp = lpend.pop_front();
        chk("div_launch", 32'(dif.div_launch), 32'h1);
        chk("div_launch_id", 32'(dif.div_launch_id), 32'(lp.id));
        chk("div_a", 32'(dif.div_a), 32'(lp.a));
        chk("div_b", 32'(dif.div_b), 32'(lp.b));
        chk("div_rnd", 32'(dif.div_rnd), 32'(lp.rnd));
        last_a = lp.a;
      end else begin
        chk("div_launch_idle", 32'(dif.div_launch), 32'h0);
        chk("div_a_hold", 32'(dif.div_a), 32'(last_a));
      end
      if (dif.div_launch)
        dpipe.push_back('{dif.div_launch_id, fdiv(dif.div_a, dif.div_b, dif.div_rnd),
                          fst(dif.div_b, dif.div_rnd), cyc + lat});
      eg = '0;
      g = -1;
      if (cm < 8 && !dif.div_pipe_full) begin
        for (int k = 0; k < 4; k++) begin
          if (g < 0 && req_valid[(ptr_m + k) % 4]) g = (ptr_m + k) % 4;
        end
      end
      if (g >= 0) eg[g] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(eg));
      chk("rsp_valid", 32'(rsp_valid), 32'(slot_m));
      chk("seq_err", 32'(seq_err), 32'(seq_err_m));
      t = 32'(dif.div_arrive_id[1:0]);
      exp_acc_n = dif.div_arrive && slot_m[t] && !rsp_ready[t];
      chk("div_accept_n", 32'(dif.div_accept_n), 32'(exp_acc_n));
      fill = dif.div_arrive && !exp_acc_n && cm > 0;
      if (dif.div_arrive && !exp_acc_n) begin
        if (inj) inj = 1'b0;
        else if (dpipe.size() > 0) void'(dpipe.pop_front());
        if (cm == 0) seq_err_m = 1'b1;
      end
      slot_m = slot_m & ~rsp_ready;
      if (fill) slot_m[t] = 1'b1;
      if (g >= 0) begin
        lpend.push_back('{{seq_m[g], 2'(g)}, req_a[g], req_b[g], req_rnd[g]});
        exp_q[g].push_back('{fdiv(req_a[g], req_b[g], req_rnd[g]), fst(req_b[g], req_rnd[g])});
        seq_m[g] = seq_m[g] + 6'd1;
        ptr_m = (g + 1) % 4;
      end
      cm = cm + ((g >= 0) ? 1 : 0) - (fill ? 1 : 0);
      for (int i = 0; i < 4; i++) if (req_valid[i] && req_ready[i]) act[i] = 1'b0;
    end
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_model();
    drive();
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic drain(string nm);
    int n = 0;
    req_mask = '0; p_rdy = 100; p_full = 0;
    while ((dpipe.size() > 0 || slot_m != 0 || lpend.size() > 0 || act != 0 || cm != 0) && n < 400) begin
      step();
      n++;
    end
    chk({nm, "_drain_done"}, 32'(n < 400), 32'h1);
  endtask

  // Scoreboard monitor: every held response must match the oldest expected result of its requester.
  always @(negedge clk) begin : mon
    bit seen_low;
    seen_low = 1'b0;
    if (rst_n) begin
      for (int i = 0; i < 4; i++) begin
        if (rsp_valid[i]) begin
          if (exp_q[i].size() == 0) begin
            chk("rsp_unexpected", 32'(i), 32'hFF);
          end else begin
            chk("rsp_z_slot", 32'(rsp_z_slot[i]), 32'(exp_q[i][0].z));
            chk("rsp_status", 32'(rsp_status[i]), 32'(exp_q[i][0].st));
            if (!seen_low) chk("rsp_z_shared", 32'(rsp_z), 32'(exp_q[i][0].z));
            seen_low = 1'b1;
            if (rsp_ready[i]) void'(exp_q[i].pop_front());
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    clear_model();
    req_a = '0; req_b = '0; req_rnd = '0;
    drive();
    step();
    step();
    rst_n = 1'b1;

    // Single requester 2: 2.0 / 1.0
    act[2] = 1'b1; req_a[2] = 16'h4000; req_b[2] = 16'h3C00; req_rnd[2] = 3'd0;
    lat = 3;
    drive();
    n = 0;
    while (!dif.div_launch && n < 10) begin step(); n++; end
    chk("single_launch_id", 32'(dif.div_launch_id), 32'h02);
    n = 0;
    while (!rsp_valid[2] && n < 20) begin step(); n++; end
    chk("single_rsp_valid", 32'(rsp_valid), 32'h4);
    chk("single_rsp_z", 32'(rsp_z), 32'h4000);
    drain("single");

    // Fairness with credit saturation
    req_mask = 4'hF; p_req = 100; p_rdy = 100; p_full = 0; lat = 20;
    for (int i = 0; i < 60; i++) step();
    drain("fair");

    // Random traffic with divider-full and moderate backpressure
    req_mask = 4'hF; p_req = 50; p_rdy = 50; p_full = 15; lat = 5;
    for (int i = 0; i < 400; i++) step();
    drain("random");

    // Heavy backpressure to exercise accept_n and drain+refill
    req_mask = 4'hF; p_req = 70; p_rdy = 15; p_full = 0; lat = 2;
    for (int i = 0; i < 250; i++) step();
    drain("backpressure");

    // Mid-run reset with operations in flight
    req_mask = 4'hF; p_req = 100; p_rdy = 0; p_full = 0; lat = 10;
    n = 0;
    while (cm < 5 && n < 30) begin step(); n++; end
    chk("inflight_before_reset", 32'(cm >= 5), 32'h1);
    do_reset();
    req_mask = 4'h0; p_rdy = 100;
    n = 0;
    while (!dif.div_launch && n < 10) begin step(); n++; end
    chk("post_reset_seq", 32'(dif.div_launch_id[7:2]), 32'h0);
    drain("post_reset");

    // Arrival with no credit: dropped, seq_err sticky
    inj = 1'b1;
    drive();
    step();
    for (int i = 0; i < 4; i++) step();
    chk("underflow_seq_err", 32'(seq_err), 32'h1);
    chk("underflow_dropped", 32'(rsp_valid), 32'h0);
    do_reset();
    step();
    chk("seq_err_cleared", 32'(seq_err), 32'h0);

    for (int i = 0; i < 4; i++) chk("exp_q_empty", 32'(exp_q[i].size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_div_arbiter.md
# fp_div_arbiter

Shares one pipelined FP divider between `NUM_REQ` processing-element requesters. It round-robin arbitrates divide requests, tags each launch with a `{seq, requester}` ID and drives the divider's launch interface from registers. Results are steered back to the owning requester by `arrive_id`, and the arbiter applies `accept_n` backpressure when that requester's response slot is occupied. It sits between the PE array and the divider wrapper, which adds one input and one output flop stage around the divider core.

## Interface
- `NUM_REQ`, 4: number of requesters; power of two, ≥2.
- `DATA_W`, 16: operand/result width (sig_width + exp_width + 1).
- `SEQ_W`, 6: per-requester sequence-number width.
- `ID_W`, `SEQ_W + $clog2(NUM_REQ)`: divider ID width, derived (not overridable).
- `INFLIGHT_MAX`, 8: global cap on launched-but-not-delivered operations.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  NUM_REQ  request per requester.
- `req_ready`  out  NUM_REQ  request accepted this cycle; one-hot or zero.
- `req_a`, `req_b`  in  NUM_REQ×DATA_W  dividend and divisor.
- `req_rnd`  in  NUM_REQ×3  rounding mode.
- `rsp_valid`  out  NUM_REQ  result held for the requester.
- `rsp_ready`  in  NUM_REQ  requester consumes the result.
- `rsp_z`  out  DATA_W  quotient; shared bus, valid for the asserted `rsp_valid` bit(s).
- `rsp_status`  out  NUM_REQ×8  status per slot.
- `rsp_z_slot`  out  NUM_REQ×DATA_W  per-slot quotient; `rsp_z` equals `rsp_z_slot[lowest valid index]`.
- `div_a`, `div_b`  out  DATA_W  registered operands.
- `div_rnd`  out  3  registered rounding mode.
- `div_launch`  out  1  registered launch pulse.
- `div_launch_id`  out  ID_W  `{seq, requester_index}`.
- `div_pipe_full`  in  1  divider full indication.
- `div_accept_n`  out  1  divider output stall (active-high).
- `div_arrive`  in  1  result arrival.
- `div_arrive_id`  in  ID_W  ID of the arriving result.
- `div_z`  in  DATA_W  arriving quotient.
- `div_status`  in  8  arriving status.
- `seq_err`  out  1  sticky sequence error.

## Operation
- **Arbitration:** round-robin pointer `rr_ptr`. The grant goes to the first `req_valid` index at or after `rr_ptr`. The grant is issued only when `credit < INFLIGHT_MAX` and `div_pipe_full == 0`. On a grant, `rr_ptr` moves to grant+1 modulo NUM_REQ; otherwise it holds.
- **Launch:** `req_ready[g]` is combinational. The handshake happens in cycle N, and the `div_*` launch registers load in N+1 with `div_launch = 1`. With no handshake, `div_launch = 0` and the operand registers hold.
- **Sequence numbers:** `seq_cnt[i]` increments on each launch for requester i and wraps modulo 2^SEQ_W.
- **Credit counter:** increments on launch and decrements when a result is written into a slot.
  - A simultaneous increment and decrement leaves it unchanged.
  - It never exceeds `INFLIGHT_MAX` and never underflows. An arrival with `credit == 0` is dropped and sets `seq_err`.
- **Return path:** one holding slot per requester, each with `slot_valid`, z and status.
  - Target index is `t = div_arrive_id[$clog2(NUM_REQ)-1:0]`.
  - `div_accept_n = div_arrive & slot_valid[t] & ~rsp_ready[t]`. This is combinational; the divider holds the result while it is asserted.
  - When `div_arrive & ~div_accept_n`, slot t loads the result.
  - A slot drained (`rsp_valid & rsp_ready`) and refilled in the same cycle ends valid with the new data.
- **Reset values:** `req_ready` 0, `rsp_valid` 0, all `div_*` outputs 0, `div_accept_n` 0, `seq_err` 0, `credit` 0, `rr_ptr` 0, all `seq_cnt` 0. Reset mid-operation discards everything in flight.

## Timing
- Request to `div_launch`: 1 cycle.
- Peak throughput is one launch per cycle, limited by `INFLIGHT_MAX`.
- Arrival to `rsp_valid`: 1 cycle (slot register).
- End-to-end request to `rsp_valid`: 1 + divider/wrapper latency + 1.
- `rsp_valid` stays high until `rsp_ready`; response data is stable while valid.

## Configuration
- **`FP_DIV_ARB_SEQ_CHECK_EN` defined:** each slot tracks `exp_seq[i]`, which starts at 0 and increments on each accepted arrival for requester i.
  - An accepted arrival whose seq field differs from `exp_seq[t]` sets `seq_err`. `seq_err` is cleared only by reset.
  - The result is still delivered.
- **Undefined:** `exp_seq` is not built. `seq_err` is raised only by the credit-underflow case.

## Structure
- Package `fp_div_arb_pkg` holds:
  - the `div_id_t` packed struct `{seq, idx}`;
  - `STATUS_W = 8`;
  - `RND_W = 3`;
  - the `rsp_slot_t` struct `{valid, z, status}`.
- Sub-module `fp_div_rr_arb`: parameterised round-robin arbiter (request vector, enable → one-hot grant, pointer update). It is also reused by other shared-unit arbiters.

## Test plan
- **Single requester:** req 2 with a=0x4000 (2.0), b=0x3C00 (1.0) → `div_launch` one cycle later with `div_launch_id` = {0,2}; on return, `rsp_valid[2]`=1 with `rsp_z`=0x4000.
- **Fairness:** all four requesting continuously → grants 0,1,2,3,0,… with one launch per cycle until credit reaches 8. Then `req_ready` stays 0 until the first arrival is delivered.
- **Backpressure:** slot 1 full with `rsp_ready[1]`=0 and arrival ID idx=1 → `div_accept_n`=1 and slot unchanged. Raise `rsp_ready[1]` → slot drained and refilled in the same cycle; `rsp_valid[1]` stays 1 with the new z.
- **Divider full:** `div_pipe_full`=1 with credit < max → no grant, `rr_ptr` held.
- **Sequence check (macro on):** inject arrival seq=3 when `exp_seq`=0 → `seq_err` goes to 1 and stays 1; result still delivered.
- **Mid-run reset:** assert `rst_n`=0 with 5 operations in flight → all outputs at reset values and credit 0; the next request launches with seq 0.
